// File: rtl/imem_loader_pkg.sv
// Shared processor definitions for the instruction-memory loader: FSM state
// encoding and instruction field layout.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_LOAD = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  // Instruction byte layout: opcode[7:5], rs[4], rt/rd[3], imm[2:0]
  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 5;
  localparam int RS_BIT  = 4;
  localparam int RD_BIT  = 3;
  localparam int IMM_MSB = 2;
  localparam int IMM_LSB = 0;

  // Reassembles an instruction byte from its fields; the loader stores bytes
  // verbatim, so this is the identity over the shared field layout.
  function automatic logic [7:0] instr_fields(input logic [7:0] b);
    return {b[OPC_MSB:OPC_LSB], b[RS_BIT], b[RD_BIT], b[IMM_MSB:IMM_LSB]};
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Streams a length-prefixed, optionally checksummed program into instruction
// memory while holding the processor in reset.
//
// state | meaning
// IDLE  | waiting for start after reset
// LEN   | expecting the length byte
// LOAD  | writing program bytes to imem
// CSUM  | expecting the trailing XOR checksum
// DONE  | load succeeded, processor released
// ERR   | bad length or checksum, processor held
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MAX_LEN     = 255,
  parameter bit CHECKSUM_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       imem_we,
  output logic [7:0] imem_addr,
  output logic [7:0] imem_wdata,
  output logic       cpu_hold,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] load_count
);

  state_t     state, next_state;
  logic [7:0] len;
  logic [7:0] csum;
  logic       accept;
  logic       len_bad;
  logic       last_byte;
  logic       restart;

  assign accept    = in_valid & in_ready;
  assign len_bad   = (in_data == 8'd0) || (int'(in_data) > MAX_LEN);
  assign last_byte = ((load_count + 8'd1) == len);
  assign restart   = start && (state inside {ST_IDLE, ST_DONE, ST_ERR});

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: if (start) next_state = ST_LEN;
      ST_LEN:  if (accept) next_state = len_bad ? ST_ERR : ST_LOAD;
      ST_LOAD: if (accept && last_byte) next_state = CHECKSUM_EN ? ST_CSUM : ST_DONE;
      ST_CSUM: if (accept) next_state = (in_data == csum) ? ST_DONE : ST_ERR;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      in_ready <= 1'b0;
    end else begin
      state    <= next_state;
      in_ready <= next_state inside {ST_LEN, ST_LOAD, ST_CSUM};
    end
  end

  // Address and data only move on a write, so they stay stable between pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imem_we    <= 1'b0;
      imem_addr  <= 8'd0;
      imem_wdata <= 8'd0;
      load_count <= 8'd0;
      csum       <= 8'd0;
      len        <= 8'd0;
    end else begin
      imem_we <= 1'b0;
      if (restart) begin
        load_count <= 8'd0;
        csum       <= 8'd0;
      end
      if (state == ST_LEN && accept) begin
        len <= in_data;
      end
      if (state == ST_LOAD && accept) begin
        imem_we    <= 1'b1;
        imem_addr  <= load_count;
        imem_wdata <= instr_fields(in_data);
        load_count <= load_count + 8'd1;
        csum       <= csum ^ in_data;
      end
    end
  end

  assign busy     = state inside {ST_LEN, ST_LOAD, ST_CSUM};
  assign done     = (state == ST_DONE);
  assign err      = (state == ST_ERR);
  assign cpu_hold = (state != ST_DONE);

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter MAX_LEN, default 255, meaning the largest accepted program length in bytes (1..255).
REQ-002 SHALL have parameter CHECKSUM_EN, default 1, meaning a trailing XOR checksum byte is required after the program bytes.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a load.
REQ-006 SHALL have port in_valid  input  1  source presents a byte on in_data.
REQ-007 SHALL have port in_data  input  8  byte stream: length, program bytes, then checksum.
REQ-008 SHALL have port in_ready  output  1  loader accepts a byte this cycle; registered.
REQ-009 SHALL have port imem_we  output  1  instruction-memory write strobe.
REQ-010 SHALL have port imem_addr  output  8  instruction-memory write address.
REQ-011 SHALL have port imem_wdata  output  8  instruction byte (opcode[7:5], rs[4], rt/rd[3], imm[2:0]).
REQ-012 SHALL have port cpu_hold  output  1  1 holds the processor in reset.
REQ-013 SHALL have port busy, done and err  output  1 each  load in progress, load succeeded, load failed.
REQ-014 SHALL have port load_count  output  8  bytes written in the current or last load.

Function
REQ-015 SHALL implement FSM states IDLE, LEN, LOAD, CSUM, DONE and ERR.
REQ-016 SHALL transfer a byte only on a rising edge with in_valid=1 and in_ready=1; in_valid while in_ready=0 is ignored.
REQ-017 SHALL drive in_ready=1 only in LEN, LOAD and CSUM.
REQ-018 SHALL, when start=1 in IDLE, DONE or ERR: go to LEN, set busy=1 and cpu_hold=1, clear done, err, load_count and the checksum accumulator.
REQ-019 SHALL ignore start while busy=1.
REQ-020 SHALL, in LEN, take accepted byte L as the length: go to ERR if L=0 or L>MAX_LEN, else go to LOAD.
REQ-021 SHALL, in LOAD, per accepted byte b: on the next cycle pulse imem_we for exactly one cycle with imem_addr=load_count (old value) and imem_wdata=b; increment load_count; XOR b into the checksum.
REQ-022 SHALL leave LOAD once load_count reaches L: go to CSUM if CHECKSUM_EN=1, else to DONE.
REQ-023 SHALL, in CSUM, go to DONE if the accepted byte equals the checksum, else to ERR; this byte is never written to memory.
REQ-024 SHALL hold DONE with done=1, busy=0, cpu_hold=0 and in_ready=0 until start.
REQ-025 SHALL hold ERR with err=1, busy=0, cpu_hold=1 and in_ready=0 until start; bytes already written are not undone.
REQ-026 SHALL keep imem_addr and imem_wdata stable when imem_we=0 and never write at an address >= L.
REQ-027 SHALL allow in_valid to be held continuously, giving one byte per cycle with no bubbles.

Reset
REQ-028 SHALL, while reset=0, force IDLE with in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, busy=0, done=0, err=0, load_count=0 and checksum=0, independent of clk.
REQ-029 SHALL, on reset mid-load, abandon the load, issue no further writes and leave memory contents unchanged.

Structure
REQ-030 SHALL take the FSM state encoding and the instruction field positions/widths from the shared processor definitions include file.
REQ-031 SHALL be a single module with no sub-module; the top level connects imem_we, imem_addr and imem_wdata to the instruction memory write port and cpu_hold to the processor reset.

Verification
REQ-032 SHALL cover: start; bytes 0x03, 0x21, 0x4A, 0x97, 0xFC -> writes 0x21@0, 0x4A@1, 0x97@2; done=1, cpu_hold=0, load_count=3.
REQ-033 SHALL cover: the same stream with checksum 0x00 -> three writes, then err=1, cpu_hold=1, done=0.
REQ-034 SHALL cover: start; length 0x00 -> err=1 the cycle after acceptance, no imem_we pulse.
REQ-035 SHALL cover: length 0x02, in_valid toggling 1,0,0,1 with data 0x11, 0x22 and checksum 0x33 -> exactly two writes (0x11@0, 0x22@1), then done=1.
REQ-036 SHALL cover: reset driven low after the second data byte of a length-4 load -> all outputs at reset values immediately, no further writes.
REQ-037 SHALL cover: start pulsed during LOAD -> ignored, load completes unchanged; L=255 -> last write lands at address 254.
